// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multicycle controller: opcodes, ALU/writeback codes,
// FSM state encodings and trap causes.
package multicycle_control_pkg;

  localparam logic [2:0] OP_RTYPE = 3'd0;
  localparam logic [2:0] OP_ITYPE = 3'd1;
  localparam logic [2:0] OP_LW    = 3'd2;
  localparam logic [2:0] OP_SW    = 3'd3;
  localparam logic [2:0] OP_BEQ   = 3'd4;
  localparam logic [2:0] OP_BNE   = 3'd5;
  localparam logic [2:0] OP_JIN   = 3'd6;
  localparam logic [2:0] OP_JOUT  = 3'd7;

  localparam logic [2:0] ALU_NOP = 3'd0;
  localparam logic [2:0] ALU_ADD = 3'd1;
  localparam logic [2:0] ALU_SUB = 3'd2;
  localparam logic [2:0] ALU_AND = 3'd3;
  localparam logic [2:0] ALU_OR  = 3'd4;
  localparam logic [2:0] ALU_XOR = 3'd5;
  localparam logic [2:0] ALU_SLT = 3'd6;
  localparam logic [2:0] ALU_SLL = 3'd7;

  localparam logic [1:0] RS_MEM = 2'd0;
  localparam logic [1:0] RS_ALU = 2'd1;
  localparam logic [1:0] RS_PC  = 2'd2;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_TRAP   = 3'd5;

  localparam logic [1:0] TC_NONE     = 2'd0;
  localparam logic [1:0] TC_ILLEGAL  = 2'd1;
  localparam logic [1:0] TC_FETCH_TO = 2'd2;
  localparam logic [1:0] TC_MEM_TO   = 2'd3;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_LW, CLS_SW, CLS_BRANCH, CLS_JIN, CLS_JOUT
  } op_class_t;

  function automatic logic [2:0] rtype_aluop(input logic [1:0] fn);
    case (fn)
      2'd0:    rtype_aluop = ALU_ADD;
      2'd1:    rtype_aluop = ALU_SUB;
      2'd2:    rtype_aluop = ALU_AND;
      default: rtype_aluop = ALU_OR;
    endcase
  endfunction

  function automatic logic [2:0] itype_aluop(input logic [1:0] subop);
    case (subop)
      2'd0:    itype_aluop = ALU_ADD;
      2'd1:    itype_aluop = ALU_XOR;
      2'd2:    itype_aluop = ALU_SLT;
      default: itype_aluop = ALU_SLL;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// IR / memory handshake and datapath control bundle between the controller
// (master) and the datapath/memory side (slave).
interface multicycle_control_if #(
  parameter int OPCODE_W = 3,
  parameter int FUNC_W   = 4,
  parameter int ALUOP_W  = 3
);
  logic [OPCODE_W-1:0] opcode;
  logic [FUNC_W-1:0]   func;
  logic                fetch_ack;
  logic                mem_ready;
  logic                trap_clear;
  logic                fetch_req;
  logic                ir_write;
  logic                pc_write;
  logic                RegWrite;
  logic                ALUsrc;
  logic                MemWrite;
  logic                MemRead;
  logic                Branch;
  logic                JumpOut;
  logic [ALUOP_W-1:0]  ALUop;
  logic [1:0]          RegStore;
  logic                busy;
  logic                trap;
  logic [1:0]          trap_cause;

  modport master (
    input  opcode, func, fetch_ack, mem_ready, trap_clear,
    output fetch_req, ir_write, pc_write, RegWrite, ALUsrc, MemWrite, MemRead,
           Branch, JumpOut, ALUop, RegStore, busy, trap, trap_cause
  );

  modport slave (
    output opcode, func, fetch_ack, mem_ready, trap_clear,
    input  fetch_req, ir_write, pc_write, RegWrite, ALUsrc, MemWrite, MemRead,
           Branch, JumpOut, ALUop, RegStore, busy, trap, trap_cause
  );
endinterface

// File: rtl/multicycle_control_decode.sv
// Combinational instruction decode: opcode/func to control bundle plus an
// illegal-encoding flag. The FSM registers these in DECODE.
module control_decode
  import multicycle_control_pkg::*;
#(
  parameter int OPCODE_W = 3,
  parameter int FUNC_W   = 4,
  parameter int ALUOP_W  = 3
) (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNC_W-1:0]   func,
  output op_class_t           op_class,
  output logic                alusrc,
  output logic [ALUOP_W-1:0]  aluop,
  output logic [1:0]          regstore,
  output logic                illegal
);
  logic       op_hi;
  logic       func_hi;
  logic [2:0] op_lo;
  logic [1:0] subop;

  assign op_lo = opcode[2:0];
  assign subop = func[FUNC_W-1:FUNC_W-2];

  // Opcodes above 7 only exist when the field is wider than 3 bits.
  if (OPCODE_W > 3) begin : g_op_wide
    assign op_hi = |opcode[OPCODE_W-1:3];
  end else begin : g_op_narrow
    assign op_hi = 1'b0;
  end

  if (FUNC_W > 2) begin : g_func_wide
    assign func_hi = |func[FUNC_W-1:2];
  end else begin : g_func_narrow
    assign func_hi = 1'b0;
  end

  always_comb begin
    op_class = CLS_ALU;
    alusrc   = 1'b0;
    aluop    = '0;
    regstore = RS_MEM;
    illegal  = op_hi;
    case (op_lo)
      OP_RTYPE: begin
        alusrc   = 1'b1;
        regstore = RS_ALU;
        aluop    = ALUOP_W'(rtype_aluop(func[1:0]));
        illegal  = op_hi | func_hi;
      end
      OP_ITYPE: begin
        regstore = RS_ALU;
        aluop    = ALUOP_W'(itype_aluop(subop));
      end
      OP_LW: begin
        op_class = CLS_LW;
        aluop    = ALUOP_W'(ALU_ADD);
      end
      OP_SW: begin
        op_class = CLS_SW;
        aluop    = ALUOP_W'(ALU_ADD);
      end
      OP_BEQ, OP_BNE: begin
        op_class = CLS_BRANCH;
        aluop    = ALUOP_W'(ALU_SUB);
      end
      OP_JIN: begin
        op_class = CLS_JIN;
        regstore = RS_PC;
        aluop    = ALUOP_W'(ALU_NOP);
      end
      default: begin
        op_class = CLS_JOUT;
        aluop    = ALUOP_W'(ALU_NOP);
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with memory
// handshakes, phase-gated datapath enables and illegal/timeout traps.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int OPCODE_W = 3,
  parameter int FUNC_W   = 4,
  parameter int ALUOP_W  = 3,
  parameter int TIMEOUT  = 16
) (
  input logic                 CLK,
  input logic                 reset,
  multicycle_control_if.master bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [2:0]         state, state_nxt;
  logic [1:0]         cause_q, cause_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               expired;
  logic               in_body;

  op_class_t          cls_q, d_class;
  logic               alusrc_q, d_alusrc;
  logic [ALUOP_W-1:0] aluop_q, d_aluop;
  logic [1:0]         regstore_q, d_regstore;
  logic               d_illegal;

  control_decode #(
    .OPCODE_W (OPCODE_W),
    .FUNC_W   (FUNC_W),
    .ALUOP_W  (ALUOP_W)
  ) u_decode (
    .opcode   (bus.opcode),
    .func     (bus.func),
    .op_class (d_class),
    .alusrc   (d_alusrc),
    .aluop    (d_aluop),
    .regstore (d_regstore),
    .illegal  (d_illegal)
  );

  // This is the last wait cycle; a handshake now still succeeds.
  assign expired = (cnt == CNT_W'(TIMEOUT - 1));
  assign in_body = (state == ST_EXEC) || (state == ST_MEM) || (state == ST_WB);

  always_comb begin
    state_nxt = state;
    cause_nxt = cause_q;
    case (state)
      ST_FETCH: begin
        if (bus.fetch_ack) begin
          state_nxt = ST_DECODE;
        end else if (expired) begin
          state_nxt = ST_TRAP;
          cause_nxt = TC_FETCH_TO;
        end
      end
      ST_DECODE: begin
        if (d_illegal) begin
          state_nxt = ST_TRAP;
          cause_nxt = TC_ILLEGAL;
        end else begin
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_LW, CLS_SW:       state_nxt = ST_MEM;
          CLS_BRANCH, CLS_JOUT: state_nxt = ST_FETCH;
          default:              state_nxt = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (bus.mem_ready) begin
          state_nxt = (cls_q == CLS_LW) ? ST_WB : ST_FETCH;
        end else if (expired) begin
          state_nxt = ST_TRAP;
          cause_nxt = TC_MEM_TO;
        end
      end
      ST_WB:   state_nxt = ST_FETCH;
      ST_TRAP: if (bus.trap_clear) state_nxt = ST_FETCH;
      default: state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state      <= ST_FETCH;
      cause_q    <= TC_NONE;
      cnt        <= '0;
      cls_q      <= CLS_ALU;
      alusrc_q   <= 1'b0;
      aluop_q    <= '0;
      regstore_q <= RS_MEM;
    end else begin
      state   <= state_nxt;
      cause_q <= cause_nxt;
      if (state_nxt != state) begin
        cnt <= '0;
      end else if (cnt != CNT_W'(TIMEOUT)) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (state == ST_DECODE) begin
        cls_q      <= d_class;
        alusrc_q   <= d_alusrc;
        aluop_q    <= d_aluop;
        regstore_q <= d_regstore;
      end
    end
  end

  // Outputs decode from state so an asynchronous reset silences them at once;
  // fetch_req is additionally held off while reset is asserted.
  assign bus.fetch_req  = reset && (state == ST_FETCH);
  assign bus.ir_write   = bus.fetch_req && bus.fetch_ack;
  assign bus.pc_write   = ((state == ST_EXEC) && ((cls_q == CLS_BRANCH) || (cls_q == CLS_JOUT)))
                       || ((state == ST_MEM) && (cls_q == CLS_SW) && bus.mem_ready)
                       || (state == ST_WB);
  assign bus.RegWrite   = (state == ST_WB);
  assign bus.MemRead    = (state == ST_MEM) && (cls_q == CLS_LW);
  assign bus.MemWrite   = (state == ST_MEM) && (cls_q == CLS_SW);
  assign bus.Branch     = (state == ST_EXEC) &&
                          ((cls_q == CLS_BRANCH) || (cls_q == CLS_JOUT) || (cls_q == CLS_JIN));
  assign bus.JumpOut    = (state == ST_EXEC) && (cls_q == CLS_JOUT);
  assign bus.ALUsrc     = in_body && alusrc_q;
  assign bus.ALUop      = in_body ? aluop_q : '0;
  assign bus.RegStore   = in_body ? regstore_q : RS_MEM;
  assign bus.busy       = (state != ST_FETCH) && (state != ST_TRAP);
  assign bus.trap       = (state == ST_TRAP);
  assign bus.trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed-vector bench for multicycle_control: per-cycle expected control
// words for each instruction class, traps, timeouts and async reset.
module tb_multicycle_control;
  logic CLK;
  logic reset;

  multicycle_control_if #(.OPCODE_W(3), .FUNC_W(4), .ALUOP_W(3)) bus ();

  multicycle_control #(
    .OPCODE_W (3),
    .FUNC_W   (4),
    .ALUOP_W  (3),
    .TIMEOUT  (16)
  ) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  localparam logic [10:0] FR = 11'h400, IW = 11'h200, PW = 11'h100, RW = 11'h080;
  localparam logic [10:0] MR = 11'h040, MW = 11'h020, BR = 11'h010, JO = 11'h008;
  localparam logic [10:0] AS = 11'h004, BZ = 11'h002, TR = 11'h001;

  logic [10:0] ctl;
  assign ctl = {bus.fetch_req, bus.ir_write, bus.pc_write, bus.RegWrite, bus.MemRead,
                bus.MemWrite, bus.Branch, bus.JumpOut, bus.ALUsrc, bus.busy, bus.trap};

  int         n_vec = 0;
  int         n_err = 0;
  logic [1:0] exp_cause = 2'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive handshakes, check outputs mid-cycle, advance.
  task automatic cyc(input string tag, input logic ack, input logic rdy, input logic clr,
                     input logic [10:0] ec, input logic [2:0] ea, input logic [1:0] er);
    bus.fetch_ack  = ack;
    bus.mem_ready  = rdy;
    bus.trap_clear = clr;
    #1;
    chk({tag, ".ctl"}, 32'(ctl), 32'(ec));
    chk({tag, ".fld"}, 32'({bus.ALUop, bus.RegStore, bus.trap_cause}), 32'({ea, er, exp_cause}));
    @(posedge CLK);
    #1;
  endtask

  task automatic fetch(input string tag, input logic [2:0] op, input logic [3:0] fn,
                       input int waits);
    bus.opcode = op;
    bus.func   = fn;
    for (int i = 0; i < waits; i++) cyc({tag, ".f"}, 1'b0, 1'b0, 1'b0, FR, 3'd0, 2'd0);
    cyc({tag, ".ack"}, 1'b1, 1'b0, 1'b0, FR | IW, 3'd0, 2'd0);
  endtask

  initial begin
    reset          = 1'b0;
    bus.opcode     = '0;
    bus.func       = '0;
    bus.fetch_ack  = 1'b0;
    bus.mem_ready  = 1'b0;
    bus.trap_clear = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    chk("rst.ctl", 32'(ctl), 32'd0);
    chk("rst.fld", 32'({bus.ALUop, bus.RegStore, bus.trap_cause}), 32'd0);
    reset = 1'b1;

    // R-type func2: ack after 2 wait cycles, ALUop=3
    fetch("r", 3'd0, 4'd2, 2);
    cyc("r.dec", 0, 0, 0, BZ, 3'd0, 2'd0);
    cyc("r.exe", 0, 0, 0, AS | BZ, 3'd3, 2'd1);
    cyc("r.wb",  0, 0, 0, RW | PW | AS | BZ, 3'd3, 2'd1);

    // I-type sub-op 1 -> ALUop 5
    fetch("i", 3'd1, 4'b0100, 0);
    cyc("i.dec", 0, 0, 0, BZ, 3'd0, 2'd0);
    cyc("i.exe", 0, 0, 0, BZ, 3'd5, 2'd1);
    cyc("i.wb",  0, 0, 0, RW | PW | BZ, 3'd5, 2'd1);

    // LW with 3-cycle memory wait
    fetch("lw", 3'd2, 4'd0, 0);
    cyc("lw.dec", 0, 0, 0, BZ, 3'd0, 2'd0);
    cyc("lw.exe", 0, 0, 0, BZ, 3'd1, 2'd0);
    for (int i = 0; i < 3; i++) cyc("lw.mem", 0, 0, 0, MR | BZ, 3'd1, 2'd0);
    cyc("lw.rdy", 0, 1, 0, MR | BZ, 3'd1, 2'd0);
    cyc("lw.wb",  0, 0, 0, RW | PW | BZ, 3'd1, 2'd0);

    // SW zero wait
    fetch("sw", 3'd3, 4'd0, 0);
    cyc("sw.dec", 0, 0, 0, BZ, 3'd0, 2'd0);
    cyc("sw.exe", 0, 0, 0, BZ, 3'd1, 2'd0);
    cyc("sw.mem", 0, 1, 0, MW | PW | BZ, 3'd1, 2'd0);

    // Branch op5, jump-out op7, jump-in op6
    fetch("br", 3'd5, 4'd0, 0);
    cyc("br.dec", 0, 0, 0, BZ, 3'd0, 2'd0);
    cyc("br.exe", 0, 0, 0, BR | PW | BZ, 3'd2, 2'd0);
    fetch("jo", 3'd7, 4'd0, 0);
    cyc("jo.dec", 0, 0, 0, BZ, 3'd0, 2'd0);
    cyc("jo.exe", 0, 0, 0, BR | JO | PW | BZ, 3'd0, 2'd0);
    fetch("ji", 3'd6, 4'd0, 0);
    cyc("ji.dec", 0, 0, 0, BZ, 3'd0, 2'd0);
    cyc("ji.exe", 0, 0, 0, BR | BZ, 3'd0, 2'd2);
    cyc("ji.wb",  0, 0, 0, RW | PW | BZ, 3'd0, 2'd2);

    // Illegal R-type func5 -> trap cause 1
    fetch("ill", 3'd0, 4'd5, 0);
    cyc("ill.dec", 0, 0, 0, BZ, 3'd0, 2'd0);
    exp_cause = 2'd1;
    cyc("ill.trap", 0, 0, 0, TR, 3'd0, 2'd0);
    cyc("ill.clr",  0, 0, 1, TR, 3'd0, 2'd0);

    // SW with no mem_ready: 16 MemWrite cycles then trap cause 3
    fetch("swto", 3'd3, 4'd0, 0);
    cyc("swto.dec", 0, 0, 0, BZ, 3'd0, 2'd0);
    cyc("swto.exe", 0, 0, 0, BZ, 3'd1, 2'd0);
    for (int i = 0; i < 16; i++) cyc("swto.mem", 0, 0, 0, MW | BZ, 3'd1, 2'd0);
    exp_cause = 2'd3;
    cyc("swto.trap", 0, 0, 1, TR, 3'd0, 2'd0);

    // SW with mem_ready on the 16th wait cycle retires normally
    fetch("sw16", 3'd3, 4'd0, 0);
    cyc("sw16.dec", 0, 0, 0, BZ, 3'd0, 2'd0);
    cyc("sw16.exe", 0, 0, 0, BZ, 3'd1, 2'd0);
    for (int i = 0; i < 15; i++) cyc("sw16.mem", 0, 0, 0, MW | BZ, 3'd1, 2'd0);
    cyc("sw16.rdy", 0, 1, 0, MW | PW | BZ, 3'd1, 2'd0);

    // Fetch with no ack -> trap cause 2
    for (int i = 0; i < 16; i++) cyc("fto.f", 0, 0, 0, FR, 3'd0, 2'd0);
    exp_cause = 2'd2;
    cyc("fto.trap", 0, 0, 1, TR, 3'd0, 2'd0);

    // Async reset while LW is in MEM
    fetch("ar", 3'd2, 4'd0, 0);
    cyc("ar.dec", 0, 0, 0, BZ, 3'd0, 2'd0);
    cyc("ar.exe", 0, 0, 0, BZ, 3'd1, 2'd0);
    cyc("ar.mem", 0, 0, 0, MR | BZ, 3'd1, 2'd0);
    #1;
    chk("ar.pre", 32'(ctl), 32'(MR | BZ));
    reset = 1'b0;
    #1;
    exp_cause = 2'd0;
    chk("ar.ctl", 32'(ctl), 32'd0);
    chk("ar.fld", 32'({bus.ALUop, bus.RegStore, bus.trap_cause}), 32'd0);
    @(posedge CLK);
    #1;
    reset = 1'b1;
    fetch("ar.after", 3'd7, 4'd0, 1);
    cyc("ar.dec2", 0, 0, 0, BZ, 3'd0, 2'd0);
    cyc("ar.exe2", 0, 0, 0, BR | JO | PW | BZ, 3'd0, 2'd0);
    cyc("ar.ret", 0, 0, 0, FR, 3'd0, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Parametrised, sequential successor to the single-cycle combinational decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB with req/ack handshakes to instruction and data memory.
- Gates datapath enables (register write, memory read/write, PC write, IR write) to the correct phase.
- Traps on illegal encodings and memory timeouts. Sits between the IR/memory interface and the existing datapath, and drives the same control signal set plus phase strobes.

Parameters:
- OPCODE_W, 3, opcode field width; decode uses opcode values 0..7, and any higher value is illegal.
- FUNC_W, 4, func field width (must be ≥2); the I-type sub-op is func[FUNC_W-1:FUNC_W-2].
- ALUOP_W, 3, ALUop width (must be ≥3).
- TIMEOUT, 16, maximum wait cycles for fetch_ack or mem_ready before a timeout trap (≥2).

Ports:
- CLK  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  OPCODE_W  opcode from IR; valid from DECODE onward.
- func  in  FUNC_W  func field from IR.
- fetch_ack  in  1  instruction memory has returned instr this cycle.
- mem_ready  in  1  data memory has completed the access.
- trap_clear  in  1  leave TRAP.
- fetch_req  out  1  instruction fetch request.
- ir_write  out  1  latch IR.
- pc_write  out  1  update PC (datapath selects target via Branch/JumpOut).
- RegWrite, ALUsrc, MemWrite, MemRead, Branch, JumpOut  out  1 each  datapath controls.
- ALUop  out  ALUOP_W  ALU operation.
- RegStore  out  2  writeback source select.
- busy  out  1  high in every state except FETCH-idle and TRAP.
- trap  out  1  sticky trap flag.
- trap_cause  out  2  1 = illegal instruction, 2 = fetch timeout, 3 = memory timeout.

Behaviour:
- Reset (async, reset=0): state=FETCH, wait counter=0, decoded register=0, trap=0, trap_cause=0, and all outputs 0. fetch_req asserts in the first cycle after reset is released.
- Decode table (registered in DECODE):
  - op0 R-type: ALUsrc=1, RegStore=1, ALUop=func+1 for func 0..3; func≥4 is illegal.
  - op1 I-type: ALUsrc=0, RegStore=1, ALUop by sub-op {0:1, 1:5, 2:6, 3:7}.
  - op2 LW: ALUop=1, RegStore=0.
  - op3 SW: ALUop=1.
  - op4/5 branch: ALUop=2.
  - op6 jump-in: RegStore=2, ALUop=0.
  - op7 jump-out: ALUop=0.
- ALUsrc, ALUop and RegStore hold their decoded values from the cycle after DECODE until the instruction retires. They are 0 in FETCH and TRAP.
- FETCH: fetch_req=1 until fetch_ack. On the ack cycle, ir_write=1 and next state is DECODE. If the counter reaches TIMEOUT without ack, go to TRAP with cause 2.
- DECODE: 1 cycle. Illegal encoding goes to TRAP with cause 1; otherwise go to EXEC.
- EXEC: 1 cycle.
  - Branch/jump-out: Branch=1, JumpOut=(op7), pc_write=1, then FETCH.
  - LW/SW: go to MEM.
  - R/I/jump-in: go to WB. For jump-in, Branch=1 in EXEC.
- MEM: MemRead (LW) or MemWrite (SW) held high until mem_ready.
  - SW on ready: pc_write=1, then FETCH.
  - LW on ready: go to WB.
  - Counter reaches TIMEOUT: drop MemRead/MemWrite that cycle, go to TRAP with cause 3.
- WB: 1 cycle, RegWrite=1 and pc_write=1, then FETCH.
- TRAP: all enables 0, trap=1. trap_clear=1 returns to FETCH next cycle with trap=0. trap_cause holds until the next trap or reset.
- Wait counter: clears on every state entry, increments each waiting cycle, and saturates. A handshake arriving on the same cycle the counter reaches TIMEOUT counts as success, not a trap.
- RegWrite, MemWrite and pc_write are never high simultaneously with trap=1.
- Reset asserted mid-instruction (e.g. during MEM) aborts immediately, with no partial writes.
- Retire latency with zero-wait memory:
  - R/I/jump-in: 4 cycles (F, D, E, WB).
  - Branch/jump-out: 3 cycles.
  - SW: 4 cycles.
  - LW: 5 cycles.

Decomposition:
- Shared package: opcode constants (OP_RTYPE..OP_JOUT), ALUop codes (ALU_NOP=0, ADD=1, SUB=2, …, 7), RegStore codes (MEM=0, ALU=1, PC=2), state enum, and trap-cause constants.
- Sub-module control_decode: a combinational decode of opcode/func into the control bundle plus an illegal flag. The FSM registers its outputs.

Test Plan:
- Reset release, then fetch_ack after 2 cycles with op0/func2: fetch_req high for 3 cycles, ir_write one pulse, ALUop=3 and ALUsrc=1 in EXEC, RegWrite=1 and pc_write=1 in WB, total 6 cycles.
- LW (op2) with mem_ready delayed 3 cycles: MemRead high exactly 4 cycles, then WB with RegStore=0 and RegWrite=1. SW (op3) with zero wait: MemWrite 1 cycle, pc_write in the same cycle, RegWrite never high.
- op5 branch: Branch=1, ALUop=2, pc_write=1 in EXEC, return to FETCH. op7: additionally JumpOut=1.
- op0/func5: trap=1, cause=1, no pc_write/RegWrite. trap_clear pulse returns to FETCH and fetch_req=1 on the next cycle.
- SW with mem_ready never asserted, TIMEOUT=16: MemWrite drops after 16 wait cycles, trap cause=3. mem_ready arriving exactly on cycle 16 gives a normal retire.
- reset pulled low while in MEM with MemRead=1: all outputs 0 asynchronously (before the next CLK edge). After release, the FSM restarts in FETCH.
